// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM bus arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_XFER = 2'd1,
        DMA_XFER = 2'd2,
        CPU_HOLD = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } grant_e;

    localparam int          CNT_W        = 8;
    localparam logic [63:0] TIMEOUT_DATA = '1;

endpackage

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM platform bus between the 6502 data path and a DMA requester,
// holding each strobe until acknowledge or a bounded-wait timeout.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_rwb,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_read,
    output logic              bus_write,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q;
    grant_e            last_grant_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic              bus_read_q, bus_write_q;
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
    logic              cpu_done_q, dma_ack_q, bus_err_q;
    logic              xfer_end;
    logic [DATA_W-1:0] end_data;

    always_comb begin
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        xfer_end = bus_ack || (cnt_q == TO_LAST);
        end_data = bus_ack ? bus_rdata : TIMEOUT_DATA[DATA_W-1:0];
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_DMA;
            cnt_q        <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_read_q   <= 1'b0;
            bus_write_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            cpu_done_q   <= 1'b0;
            dma_ack_q    <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            dma_ack_q <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    // On a tie the port that did not win last time goes first
                    if (cpu_req && (!dma_req || last_grant_q == GNT_DMA)) begin
                        bus_addr_q   <= cpu_addr;
                        bus_wdata_q  <= cpu_wdata;
                        bus_read_q   <= cpu_rwb;
                        bus_write_q  <= !cpu_rwb;
                        last_grant_q <= GNT_CPU;
                        state_q      <= CPU_XFER;
                    end else if (dma_req) begin
                        bus_addr_q   <= dma_addr;
                        bus_wdata_q  <= dma_wdata;
                        bus_read_q   <= !dma_we;
                        bus_write_q  <= dma_we;
                        last_grant_q <= GNT_DMA;
                        state_q      <= DMA_XFER;
                    end
                end
                CPU_XFER, DMA_XFER: begin
                    cnt_q <= cnt_d;
                    if (xfer_end) begin
                        bus_read_q  <= 1'b0;
                        bus_write_q <= 1'b0;
                        bus_err_q   <= !bus_ack;
                        if (state_q == CPU_XFER) begin
                            if (bus_read_q) cpu_rdata_q <= end_data;
                            cpu_done_q <= 1'b1;
                            state_q    <= CPU_HOLD;
                        end else begin
                            if (bus_read_q) dma_rdata_q <= end_data;
                            dma_ack_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                end
                CPU_HOLD: begin
                    // Wait out the rest of a long CPU cycle so it cannot trigger a repeat access
                    if (!cpu_req) begin
                        cpu_done_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign dma_rdata = dma_rdata_q;
    assign dma_ack   = dma_ack_q;
    assign bus_addr  = bus_addr_q;
    assign bus_read  = bus_read_q;
    assign bus_write = bus_write_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: table vectors, directed corner cases and random transactions.
module tb_sdram_arbiter;

    localparam int TIMEOUT = 64;

    logic        clk_50 = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_rwb, cpu_done;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic [15:0] bus_addr;
    logic        bus_read, bus_write, bus_ack, bus_err;
    logic [7:0]  bus_wdata, bus_rdata;

    sdram_arbiter #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk_50(clk_50), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_rwb(cpu_rwb), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #10 clk_50 = ~clk_50;

    int checks = 0;
    int failures = 0;

    // Transaction-level reference state
    int         m_last;           // 0 = CPU won last, 1 = DMA won last
    logic [7:0] m_cpu_rd, m_dma_rd;

    // Per-port transaction descriptors used by serve()
    bit         c_rd, d_rd;
    logic [15:0] c_addr, d_addr;
    logic [7:0] c_wd, d_wd, c_rdv, d_rdv;
    int         c_lat, d_lat;
    int         obs_len, first_owner;
    logic       obs_err;
    logic [7:0] obs_rdata;

    typedef struct {
        bit          port;
        bit          rd;
        logic [15:0] addr;
        logic [7:0]  wd;
        int          lat;
        logic [7:0]  rdv;
        logic [7:0]  exp_rdata;
        int          exp_len;
        bit          exp_err;
    } vec_t;
    vec_t vecs[8];

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Runs the requested port(s) to completion acting as the SDRAM slave; ack lands on strobe cycle lat
    task automatic serve(input bit want_c, input bit want_d);
        bit pend_c, pend_d, clr, rd;
        int owner, k, guard, lat;
        logic [15:0] own_addr;
        pend_c = want_c; pend_d = want_d; clr = 0; owner = -1; k = 0; guard = 0;
        first_owner = -1; own_addr = '0;
        cpu_rwb = c_rd;  cpu_addr = c_addr; cpu_wdata = c_wd; cpu_req = want_c;
        dma_we  = !d_rd; dma_addr = d_addr; dma_wdata = d_wd; dma_req = want_d;
        while ((pend_c || pend_d || clr) && guard < 400) begin
            step();
            guard++;
            bus_ack = 1'b0;
            if (clr) begin
                chk("done_clear", cpu_done, 0);
                chk("ack_pulse", dma_ack, 0);
                chk("err_pulse", bus_err, 0);
                clr = 0;
            end
            if (bus_read || bus_write) begin
                if (owner < 0) begin
                    owner = (pend_c && pend_d) ? ((m_last == 1) ? 0 : 1) : (pend_c ? 0 : 1);
                    if (first_owner < 0) first_owner = owner;
                    m_last = owner;
                    k = 0;
                    own_addr = (owner == 0) ? c_addr : d_addr;
                    chk("grant_addr", bus_addr, own_addr);
                    chk("grant_dir", bus_read, (owner == 0) ? c_rd : d_rd);
                    if (!bus_read) chk("grant_wdata", bus_wdata, (owner == 0) ? c_wd : d_wd);
                end else begin
                    chk("hold_addr", bus_addr, own_addr);
                end
                k++;
                lat = (owner == 0) ? c_lat : d_lat;
                bus_ack = (k == lat);
                bus_rdata = (owner == 0) ? c_rdv : d_rdv;
            end else if (owner >= 0) begin
                lat = (owner == 0) ? c_lat : d_lat;
                rd  = (owner == 0) ? c_rd : d_rd;
                chk("strobe_len", k, (lat > TIMEOUT) ? TIMEOUT : lat);
                chk("bus_err", bus_err, lat > TIMEOUT);
                if (owner == 0) begin
                    if (rd) m_cpu_rd = (lat > TIMEOUT) ? 8'hFF : c_rdv;
                    chk("cpu_done", cpu_done, 1);
                    chk("cpu_rdata", cpu_rdata, m_cpu_rd);
                    chk("no_dma_ack", dma_ack, 0);
                    obs_rdata = cpu_rdata;
                    cpu_req = 1'b0;
                    pend_c = 0;
                end else begin
                    if (rd) m_dma_rd = (lat > TIMEOUT) ? 8'hFF : d_rdv;
                    chk("dma_ack", dma_ack, 1);
                    chk("dma_rdata", dma_rdata, m_dma_rd);
                    chk("no_cpu_done", cpu_done, 0);
                    obs_rdata = dma_rdata;
                    dma_req = 1'b0;
                    pend_d = 0;
                end
                obs_len = k;
                obs_err = bus_err;
                clr = 1;
                owner = -1;
            end
        end
        if (guard >= 400) begin
            checks++;
            failures++;
            $display("FAIL serve_bound cycles=%0d required_below=400", guard);
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        bus_ack = 1'b0;
    endtask

    task automatic wait_strobe(output int w);
        w = 0;
        while (!(bus_read || bus_write) && w < 10) begin
            step();
            w++;
        end
    endtask

    initial begin
        int w, nw, owner, mode, r;
        int exp_own[3];
        exp_own = '{0, 1, 0};

        vecs[0] = '{1'b0, 1'b1, 16'h8010, 8'h00, 3,   8'h5A, 8'h5A, 3,  1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h1234, 8'hC3, 1,   8'h00, 8'h00, 1,  1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'h0042, 8'h00, 70,  8'h3C, 8'hFF, 64, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 16'h8000, 8'h33, 64,  8'h00, 8'h5A, 64, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 8'h00, 100, 8'h12, 8'hFF, 64, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 16'h0000, 8'h00, 2,   8'h00, 8'h00, 2,  1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h4321, 8'h00, 1,   8'hA5, 8'hA5, 1,  1'b0};
        vecs[7] = '{1'b1, 1'b0, 16'h0001, 8'hEE, 65,  8'h00, 8'h00, 64, 1'b1};

        rst_n = 1'b0; cpu_req = 0; cpu_rwb = 1; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; bus_ack = 0; bus_rdata = 0;
        m_last = 1; m_cpu_rd = 0; m_dma_rd = 0;
        step(); step();
        chk("rst_strobes", {bus_read, bus_write}, 0);
        chk("rst_flags", {cpu_done, dma_ack, bus_err}, 0);
        chk("rst_bus_regs", {bus_addr, bus_wdata}, 0);
        chk("rst_rdata", {cpu_rdata, dma_rdata}, 0);
        rst_n = 1'b1;
        step();

        // Tie straight after reset: CPU first, then DMA
        c_rd = 1; c_addr = 16'h1000; c_wd = 0;     c_lat = 1; c_rdv = 8'h11;
        d_rd = 0; d_addr = 16'h2000; d_wd = 8'h99; d_lat = 1; d_rdv = 8'h00;
        serve(1, 1);
        chk("tie_first", first_owner, 0);

        foreach (vecs[i]) begin
            if (vecs[i].port == 0) begin
                c_rd = vecs[i].rd; c_addr = vecs[i].addr; c_wd = vecs[i].wd;
                c_lat = vecs[i].lat; c_rdv = vecs[i].rdv;
            end else begin
                d_rd = vecs[i].rd; d_addr = vecs[i].addr; d_wd = vecs[i].wd;
                d_lat = vecs[i].lat; d_rdv = vecs[i].rdv;
            end
            serve(vecs[i].port == 0, vecs[i].port == 1);
            chk("vec_rdata", obs_rdata, vecs[i].exp_rdata);
            chk("vec_len", obs_len, vecs[i].exp_len);
            chk("vec_err", obs_err, vecs[i].exp_err);
        end

        // Both kept pending: grants alternate CPU, DMA, CPU
        cpu_rwb = 0; cpu_addr = 16'h1111; cpu_wdata = 8'h01; cpu_req = 1;
        dma_we  = 1; dma_addr = 16'h2222; dma_wdata = 8'h02; dma_req = 1;
        for (int g = 0; g < 3; g++) begin
            wait_strobe(w);
            chk("alt_strobe_seen", w < 10, 1);
            owner = (bus_addr == 16'h1111) ? 0 : 1;
            chk("alt_grant", owner, exp_own[g]);
            bus_ack = 1'b1;
            step();
            bus_ack = 1'b0;
            if (owner == 0) begin
                chk("alt_cpu_done", cpu_done, 1);
                cpu_req = 0;
                if (g == 2) dma_req = 0;
                step();
                if (g != 2) cpu_req = 1;
            end else begin
                chk("alt_dma_ack", dma_ack, 1);
            end
        end
        step();
        chk("alt_end_idle", {bus_read, bus_write, cpu_done}, 0);
        m_last = 0;

        // Write with cpu_req held for 20 cycles: exactly one bus write
        cpu_rwb = 0; cpu_addr = 16'h8000; cpu_wdata = 8'h33; cpu_req = 1; nw = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            bus_ack = bus_write;
            if (bus_write) begin
                nw++;
                chk("held_addr", bus_addr, 16'h8000);
                chk("held_wdata", bus_wdata, 8'h33);
            end
        end
        bus_ack = 0;
        chk("held_writes", nw, 1);
        chk("held_done", cpu_done, 1);
        cpu_req = 0;
        step();
        chk("held_release", cpu_done, 0);

        // cpu_req dropped mid-transfer: write still completes, done for one cycle
        cpu_rwb = 0; cpu_addr = 16'h0300; cpu_wdata = 8'h77; cpu_req = 1;
        step();
        chk("drop_strobe", bus_write, 1);
        cpu_req = 0;
        step(); step();
        chk("drop_still", bus_write, 1);
        bus_ack = 1;
        step();
        bus_ack = 0;
        chk("drop_done", cpu_done, 1);
        chk("drop_strobe_off", bus_write, 0);
        step();
        chk("drop_done_clr", cpu_done, 0);
        step();
        chk("drop_idle", {bus_read, bus_write}, 0);

        // Random transactions against the transaction-level model
        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(1, 3);
            c_rd = $urandom % 2; c_addr = 16'($urandom); c_wd = 8'($urandom); c_rdv = 8'($urandom);
            d_rd = $urandom % 2; d_addr = c_addr ^ 16'h8000; d_wd = 8'($urandom); d_rdv = 8'($urandom);
            r = $urandom_range(0, 9);
            c_lat = (r < 8) ? r + 1 : ((r == 8) ? TIMEOUT : TIMEOUT + 1 + $urandom_range(0, 3));
            r = $urandom_range(0, 9);
            d_lat = (r < 8) ? r + 1 : ((r == 8) ? TIMEOUT : TIMEOUT + 1 + $urandom_range(0, 3));
            serve(mode[0], mode[1]);
        end

        // Reset asserted during a DMA read drops the strobe without waiting for a clock
        dma_we = 0; dma_addr = 16'h0ABC; dma_req = 1;
        step(); step();
        chk("rstx_strobe", bus_read, 1);
        #4 rst_n = 1'b0;
        #1;
        chk("rstx_async_drop", {bus_read, bus_write}, 0);
        chk("rstx_flags", {cpu_done, dma_ack, bus_addr}, 0);
        dma_req = 0;
        step(); step();
        rst_n = 1'b1;
        m_last = 1; m_cpu_rd = 0; m_dma_rd = 0;
        c_rd = 1; c_addr = 16'h0100; c_lat = 2; c_rdv = 8'h42;
        d_rd = 1; d_addr = 16'h0200; d_lat = 1; d_rdv = 8'h24;
        serve(1, 1);
        chk("rstx_tie_first", first_owner, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter and sequencer for the SDRAM platform's external bus (address / read / write / write_data / acknowledge / read_data). It shares the bus between the 6502 data path and a DMA requester, and holds each strobe until acknowledge. It issues exactly one SDRAM transaction per CPU request assertion. A bounded-wait timeout guarantees the CPU never stalls on a missing acknowledge.

## Interface
- ADDR_W, 16: address width of both requester ports and the bus.
- DATA_W, 8: data width.
- TIMEOUT, 64: cycles to wait for bus_ack before aborting; 2..255.
- clk_50  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  level; CPU access valid (chip select qualified by phi2).
- cpu_rwb  in  1  1 = read, 0 = write.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  latched read data.
- cpu_done  out  1  transaction finished; held until cpu_req falls.
- dma_req  in  1  level; held until dma_ack.
- dma_we  in  1  1 = write.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_rdata  out  DATA_W  latched read data.
- dma_ack  out  1  one-cycle completion pulse.
- bus_addr  out  ADDR_W  registered bus address.
- bus_read  out  1  registered read strobe.
- bus_write  out  1  registered write strobe.
- bus_wdata  out  DATA_W  registered write data.
- bus_ack  in  1  acknowledge from the SDRAM platform.
- bus_rdata  in  DATA_W  read data; valid when bus_ack = 1.
- bus_err  out  1  one-cycle pulse on timeout.

## Operation
- States: IDLE, CPU_XFER, DMA_XFER, CPU_HOLD.
- IDLE, one request pending: grant it.
- IDLE, both pending: grant the port not granted last.
  - last_grant resets to DMA, so the CPU wins the first tie.
- Grant:
  - Latch address, write data and direction into bus_* registers.
  - Assert bus_read or bus_write.
  - Clear wait counter.
- XFER: strobe, address and wdata stay stable until bus_ack is sampled high or the counter reaches TIMEOUT-1.
- On ack:
  - Read: capture bus_rdata into the granted port's rdata.
  - Write: leave rdata unchanged.
  - Drop the strobe.
  - CPU: go to CPU_HOLD and assert cpu_done.
  - DMA: go to IDLE and pulse dma_ack.
- On timeout (no ack):
  - Drop the strobe and pulse bus_err.
  - Reads: load rdata with all ones.
  - Complete to the requester exactly as on ack.
- CPU_HOLD: cpu_done stays high while cpu_req = 1; on cpu_req = 0, go to IDLE and clear cpu_done.
  - This prevents repeat writes during one long CPU cycle.
- cpu_req falling during CPU_XFER: the transaction still completes. CPU_HOLD then exits on the next cycle.
- dma_req sampled only in IDLE. Dropping it mid-transfer has no effect.
- Reset values: all strobes, cpu_done, dma_ack and bus_err = 0; rdata, bus_addr and bus_wdata = 0; state IDLE.
  - Reset mid-transfer drops the strobe immediately.

## Timing
- Request high at edge N in IDLE → strobe high from N+1.
- bus_ack high at edge M → strobe low at M+1.
  - Also at M+1: rdata valid, cpu_done high or dma_ack pulse.
- Minimum transaction with ack at the first strobe cycle: 2 cycles request-to-done.
- Timeout: strobe high for exactly TIMEOUT cycles; bus_err and done at the following edge.
- Back-to-back DMA: next grant at earliest one cycle after dma_ack (IDLE visited for one cycle).
- Counter width 8 bits; saturates, never wraps.

## Structure
- Package sdram_arb_pkg holds:
  - the state enum (IDLE, CPU_XFER, DMA_XFER, CPU_HOLD);
  - the grant enum (GNT_CPU, GNT_DMA);
  - the timeout-data constant (all ones).
- Single module, no sub-module.
  - The wait counter and grant memory are small enough to stay inline.

## Test plan
- CPU read 0x8010, ack on 3rd strobe cycle, bus_rdata 0x5A:
  - bus_read high exactly 3 cycles;
  - cpu_rdata = 0x5A and cpu_done high;
  - cpu_done low one cycle after cpu_req falls.
- CPU write 0x8000 = 0x33 with cpu_req held 20 cycles, immediate ack:
  - exactly one bus_write pulse;
  - no second write until cpu_req toggles.
- Both requests high in IDLE after reset:
  - CPU granted first, then DMA;
  - with both kept pending, grants alternate CPU, DMA, CPU.
- DMA read, bus_ack never asserted, TIMEOUT = 64:
  - bus_read high 64 cycles;
  - bus_err pulse, dma_rdata = 0xFF, dma_ack pulse.
- rst_n low during DMA_XFER:
  - bus_read and bus_write drop asynchronously;
  - state IDLE; first tie after release goes to CPU.
- cpu_req dropped during CPU_XFER:
  - write completes on ack;
  - cpu_done high one cycle, then IDLE.
